// File: rtl/reg_bus_initiator.sv
// reg_bus_initiator: takes read / write / read-modify-write commands on a
// valid/ready port, drives single-cycle register bus strobes, captures read
// data after a fixed latency and returns one response per command.
module reg_bus_initiator #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [1:0]  i_cmd_op,
  input  logic [31:0] i_cmd_addr,
  input  logic [31:0] i_cmd_wdata,
  input  logic [31:0] i_cmd_mask,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_write,
  output logic        o_read,
  output logic [31:0] o_addr,
  output logic [31:0] o_wdata,
  input  logic [31:0] i_rdata
);

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_RMW = 2'b10;
  localparam logic [3:0] LAT    = 4'(RD_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD, S_WAIT, S_MOD, S_RSP
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mask_q, mask_d;
  logic [3:0]  cnt_q, cnt_d;

  // registered outputs
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        write_q, write_d;
  logic        read_q, read_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;

  // Next-state and next-output logic. Outputs are computed for the state being
  // entered so every bus and response signal comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    addr_d      = addr_q;
    bus_wdata_d = bus_wdata_q;
    write_d     = 1'b0;
    read_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          op_d        = i_cmd_op;
          wdata_d     = i_cmd_wdata;
          mask_d      = i_cmd_mask;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          case (i_cmd_op)
            OP_WR: begin
              state_d     = S_WR;
              write_d     = 1'b1;
              addr_d      = i_cmd_addr;
              bus_wdata_d = i_cmd_wdata;
            end
            OP_RD, OP_RMW: begin
              state_d = S_RD;
              read_d  = 1'b1;
              addr_d  = i_cmd_addr;
            end
            default: begin
              // illegal op: no bus traffic, error response next cycle
              state_d   = S_RSP;
              rsp_err_d = 1'b1;
            end
          endcase
        end
      end
      S_WR: state_d = S_RSP;
      S_RD: begin
        cnt_d   = LAT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // counter at 1 marks the cycle the read data is valid on the bus
        if (cnt_q == 4'd1) begin
          rsp_rdata_d = i_rdata;
          if (op_q == OP_RMW) begin
            state_d     = S_MOD;
            write_d     = 1'b1;
            bus_wdata_d = (i_rdata & ~mask_q) | (wdata_q & mask_q);
          end else begin
            state_d = S_RSP;
          end
        end
      end
      S_MOD: state_d = S_RSP;
      S_RSP: if (i_rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RSP);
  end

  // State and output registers; reset drops any in-flight command.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_WR;
      wdata_q     <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      addr_q      <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      write_q     <= write_d;
      read_q      <= read_d;
      addr_q      <= addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign o_cmd_ready = cmd_ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_write     = write_q;
  assign o_read      = read_q;
  assign o_addr      = addr_q;
  assign o_wdata     = bus_wdata_q;

endmodule

// File: tb/tb_reg_bus_initiator.sv
// Bench for reg_bus_initiator: directed commands against a small register
// file, a transaction-level model that predicts every output each cycle, and
// literal latency / data expectations on the directed vectors.
module tb_reg_bus_initiator;

  localparam int L = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic [1:0]  i_cmd_op = 2'b00;
  logic [31:0] i_cmd_addr = '0;
  logic [31:0] i_cmd_wdata = '0;
  logic [31:0] i_cmd_mask = '0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b1;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic        o_write;
  logic        o_read;
  logic [31:0] o_addr;
  logic [31:0] o_wdata;
  logic [31:0] rf_rdata = '0;

  reg_bus_initiator #(.RD_LATENCY(L)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_op(i_cmd_op), .i_cmd_addr(i_cmd_addr),
    .i_cmd_wdata(i_cmd_wdata), .i_cmd_mask(i_cmd_mask),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_write(o_write), .o_read(o_read), .o_addr(o_addr),
    .o_wdata(o_wdata), .i_rdata(rf_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // attached register file: registered read, one cycle of latency
  logic [31:0] rf [16] = '{default: 32'h0};
  always @(posedge clk) begin
    if (o_read)  rf_rdata <= rf[o_addr[5:2]];
    if (o_write) rf[o_addr[5:2]] <= o_wdata;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // transaction-level model: one outstanding command, scheduled by cycle number
  bit          busy = 1'b0;
  int          rd_cyc = -1, wr_cyc = -1, rsp_from = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  bit          m_err = 1'b0;
  logic [31:0] mm [16] = '{default: 32'h0};
  bit          acc_flag = 1'b0;

  // per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    bit rdy, ev;
    int a;
    if (!rst_n) begin
      busy = 1'b0; rd_cyc = -1; wr_cyc = -1;
      chk("rst_cmd_ready", o_cmd_ready, 1);
      chk("rst_rsp_valid", o_rsp_valid, 0);
      chk("rst_rsp_rdata", o_rsp_rdata, 0);
      chk("rst_rsp_err",   o_rsp_err, 0);
      chk("rst_write",     o_write, 0);
      chk("rst_read",      o_read, 0);
      chk("rst_addr",      o_addr, 0);
      chk("rst_wdata",     o_wdata, 0);
    end else begin
      rdy = !busy;
      chk("cmd_ready", o_cmd_ready, rdy);
      chk("read_strobe", o_read, cyc == rd_cyc);
      chk("write_strobe", o_write, cyc == wr_cyc);
      if (cyc == rd_cyc || cyc == wr_cyc) chk("bus_addr", o_addr, m_addr);
      if (cyc == wr_cyc) begin
        chk("bus_wdata", o_wdata, m_wdata);
        mm[m_addr[5:2]] = m_wdata;
      end
      ev = busy && (cyc >= rsp_from);
      chk("rsp_valid", o_rsp_valid, ev);
      if (ev) begin
        chk("rsp_rdata", o_rsp_rdata, m_rdata);
        chk("rsp_err", o_rsp_err, m_err);
        if (i_rsp_ready) busy = 1'b0;
      end
      if (rdy && i_cmd_valid) begin
        a = cyc + 1;                 // cycle right after the accepting edge
        acc_flag = 1'b1;
        busy = 1'b1; rd_cyc = -1; wr_cyc = -1;
        m_err = 1'b0; m_rdata = '0;
        m_addr = i_cmd_addr;
        case (i_cmd_op)
          2'b00: begin m_wdata = i_cmd_wdata; wr_cyc = a; rsp_from = a + 1; end
          2'b01: begin rd_cyc = a; m_rdata = mm[i_cmd_addr[5:2]]; rsp_from = a + 1 + L; end
          2'b10: begin
            rd_cyc = a; m_rdata = mm[i_cmd_addr[5:2]];
            m_wdata = (m_rdata & ~i_cmd_mask) | (i_cmd_wdata & i_cmd_mask);
            wr_cyc = a + 1 + L; rsp_from = a + 2 + L;
          end
          default: begin m_err = 1'b1; rsp_from = a; end
        endcase
      end
    end
  end

  int t0;

  task automatic issue(input logic [1:0] op, input logic [31:0] ad, input logic [31:0] wd,
                       input logic [31:0] mk);
    @(posedge clk); #1;
    acc_flag = 1'b0;
    i_cmd_valid = 1'b1; i_cmd_op = op; i_cmd_addr = ad; i_cmd_wdata = wd; i_cmd_mask = mk;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (acc_flag) break;
    end
    if (!acc_flag) chk("accept_timeout", 0, 1);
    t0 = cyc;
    i_cmd_valid = 1'b0;
    i_cmd_op = 2'($urandom); i_cmd_addr = $urandom; i_cmd_wdata = $urandom; i_cmd_mask = $urandom;
  endtask

  // wait for the response, pin latency/data to literals, let the handshake happen
  task automatic wait_rsp(input string nm, input int lat, input logic [31:0] rd, input logic er);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_rsp_valid) begin seen = 1'b1; break; end
    end
    if (!seen) chk({nm, "_rsp_timeout"}, 0, 1);
    else begin
      if (lat >= 0) chk({nm, "_latency"}, cyc - t0, lat);
      chk({nm, "_rdata"}, o_rsp_rdata, rd);
      chk({nm, "_err"}, o_rsp_err, er);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    // reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      i_cmd_valid = 1'($urandom); i_cmd_op = 2'($urandom); i_cmd_addr = $urandom;
      i_cmd_wdata = $urandom; i_cmd_mask = $urandom; i_rsp_ready = 1'($urandom);
    end
    @(posedge clk); #1;
    i_cmd_valid = 1'b0; i_rsp_ready = 1'b1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // write / read / RMW on register 0
    issue(2'b00, 32'h0, 32'h0000_00C5, 32'hFFFF_FFFF);
    wait_rsp("wr", 1, 32'h0, 1'b0);
    chk("rf0_after_wr", rf[0], 32'hC5);
    issue(2'b01, 32'h0, 32'h1234_5678, 32'h0);
    wait_rsp("rd", 1 + L, 32'hC5, 1'b0);
    issue(2'b10, 32'h0, 32'h0000_0040, 32'h0000_00C0);
    wait_rsp("rmw", 2 + L, 32'hC5, 1'b0);
    chk("rf0_after_rmw", rf[0], 32'h45);
    issue(2'b01, 32'h0, 32'h0, 32'h0);
    wait_rsp("rd_after_rmw", 1 + L, 32'h45, 1'b0);

    // more patterns on register 1 and 2
    issue(2'b00, 32'h4, 32'hDEAD_BEEF, 32'h0);
    wait_rsp("wr4", 1, 32'h0, 1'b0);
    issue(2'b10, 32'h4, 32'h1234_5678, 32'hFFFF_0000);
    wait_rsp("rmw4", 2 + L, 32'hDEAD_BEEF, 1'b0);
    chk("rf1_after_rmw", rf[1], 32'h1234_BEEF);
    issue(2'b10, 32'h4, 32'hFFFF_FFFF, 32'h0);
    wait_rsp("rmw4_mask0", 2 + L, 32'h1234_BEEF, 1'b0);
    issue(2'b10, 32'h4, 32'h0F0F_0F0F, 32'hFFFF_FFFF);
    wait_rsp("rmw4_maskall", 2 + L, 32'h1234_BEEF, 1'b0);
    issue(2'b01, 32'h4, 32'h0, 32'h0);
    wait_rsp("rd4", 1 + L, 32'h0F0F_0F0F, 1'b0);
    issue(2'b01, 32'h8, 32'h0, 32'h0);
    wait_rsp("rd8_empty", 1 + L, 32'h0, 1'b0);

    // response backpressure, then an illegal op
    i_rsp_ready = 1'b0;
    issue(2'b00, 32'h8, 32'h0000_A5A5, 32'h0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("bp_rsp_valid", o_rsp_valid, 1);
    chk("bp_cmd_ready", o_cmd_ready, 0);
    @(posedge clk); #1;
    i_rsp_ready = 1'b1;
    wait_rsp("bp_wr", -1, 32'h0, 1'b0);
    issue(2'b11, 32'h4, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_rsp("illegal", 0, 32'h0, 1'b1);
    chk("rf1_after_illegal", rf[1], 32'h0F0F_0F0F);

    // reset while the RMW waits on read data: its write must never happen
    issue(2'b10, 32'h0, 32'h0000_00FF, 32'h0000_00FF);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_write", o_write, 0);
    chk("midrst_cmd_ready", o_cmd_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    chk("rf0_after_midrst", rf[0], 32'h45);
    issue(2'b01, 32'h0, 32'h0, 32'h0);
    wait_rsp("rd_after_midrst", 1 + L, 32'h45, 1'b0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
